// File: rtl/ro_freq_meter_if.sv
// Control/result bundle for the ring-oscillator frequency meter.
// The master side drives start/abort/win_len and the ring output. The slave side is the meter.
interface ro_freq_meter_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    logic             start;
    logic             abort;
    logic [WIN_W-1:0] win_len;
    logic             ro_in;
    logic             ro_en;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic             cnt_valid;
    logic             cnt_sat;

    modport master (
        output start, abort, win_len, ro_in,
        input  ro_en, busy, cnt, cnt_valid, cnt_sat
    );

    modport slave (
        input  start, abort, win_len, ro_in,
        output ro_en, busy, cnt, cnt_valid, cnt_sat
    );
endinterface

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter. It enables the ring, waits for it to settle, and then counts
// the synchronized rising edges over win_len clocks. It publishes a saturating count.
module ro_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SETTLE_CYC  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    ro_freq_meter_if.slave   bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int               SET_W       = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   edge_s;
    logic [1:0]             state_r;
    logic [1:0]             state_nxt_s;
    logic [WIN_W-1:0]       win_q_r;
    logic [WIN_W-1:0]       win_tmr_r;
    logic [SET_W-1:0]       settle_r;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_inc_s;
    logic [CNT_W-1:0]       pub_s;
    logic                   ro_en_r;
    logic                   busy_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   cnt_valid_r;
    logic                   cnt_sat_r;

    // ro_in synchronizer plus a previous-value flop, so that rising edges can be detected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.ro_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign edge_s = sync_r[SYNC_STAGES-1] & ~prev_r;

    // Saturating increment and the value published on entry to DONE.
    always_comb begin
        count_inc_s = count_r;
        pub_s       = '0;
        if (edge_s && (count_r != CNT_MAX)) begin
            count_inc_s = count_r + CNT_W'(1);
        end else begin
            count_inc_s = count_r;
        end
        if (state_r == ST_MEASURE) begin
            pub_s = count_inc_s;
        end else begin
            pub_s = '0;
        end
    end

    // Next-state logic. start is only honoured in IDLE, and abort only in SETTLE or MEASURE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_nxt_s = ST_SETTLE;
                else           state_nxt_s = ST_IDLE;
            end
            ST_SETTLE: begin
                if (bus.abort)                   state_nxt_s = ST_IDLE;
                else if (settle_r != SETTLE_LAST) state_nxt_s = ST_SETTLE;
                else if (win_q_r == '0)           state_nxt_s = ST_DONE;
                else                              state_nxt_s = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (bus.abort)                       state_nxt_s = ST_IDLE;
                else if (win_tmr_r == WIN_W'(1))     state_nxt_s = ST_DONE;
                else                                 state_nxt_s = ST_MEASURE;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and measurement datapath. The counter is cleared only when MEASURE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            win_q_r   <= '0;
            win_tmr_r <= '0;
            settle_r  <= '0;
            count_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        win_q_r  <= bus.win_len;
                        settle_r <= '0;
                    end
                end
                ST_SETTLE: begin
                    settle_r <= settle_r + SET_W'(1);
                    if (state_nxt_s == ST_MEASURE) begin
                        count_r   <= '0;
                        win_tmr_r <= win_q_r;
                    end
                end
                ST_MEASURE: begin
                    count_r   <= count_inc_s;
                    win_tmr_r <= win_tmr_r - WIN_W'(1);
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state, so that they are registered and aligned with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            cnt_r       <= '0;
            cnt_valid_r <= 1'b0;
            cnt_sat_r   <= 1'b0;
        end else begin
            ro_en_r     <= (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_MEASURE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            cnt_valid_r <= (state_nxt_s == ST_DONE);
            if (state_nxt_s == ST_DONE) begin
                cnt_r     <= pub_s;
                cnt_sat_r <= (pub_s == CNT_MAX);
            end
        end
    end

    assign bus.ro_en     = ro_en_r;
    assign bus.busy      = busy_r;
    assign bus.cnt       = cnt_r;
    assign bus.cnt_valid = cnt_valid_r;
    assign bus.cnt_sat   = cnt_sat_r;
endmodule

// File: tb/tb_ro_freq_meter.sv
// Scoreboard bench for ro_freq_meter. DUT A uses a 16-bit counter with an 8-clock ring period.
// DUT B uses a 4-bit counter with a 4-clock ring period. Both share start/abort/win_len.
module tb_ro_freq_meter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   compared   = 0;
    int   mismatched = 0;

    typedef struct {
        int vcyc;
        int lo;
        int hi;
        bit sat;
    } exp_t;
    exp_t sb[$];

    ro_freq_meter_if #(.CNT_W(16), .WIN_W(16)) ifa ();
    ro_freq_meter_if #(.CNT_W(4),  .WIN_W(16)) ifb ();

    ro_freq_meter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(8), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    ro_freq_meter #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(8), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        ifa.ro_in = 1'b0;
        #3;
        forever begin
            #40 ifa.ro_in = ~ifa.ro_in;
        end
    end

    initial begin
        ifb.ro_in = 1'b0;
        #7;
        forever begin
            #20 ifb.ro_in = ~ifb.ro_in;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic s, input logic a, input logic [15:0] wl);
        ifa.start = s; ifb.start = s;
        ifa.abort = a; ifb.abort = a;
        ifa.win_len = wl; ifb.win_len = wl;
    endtask

    // Drives one measurement and records what the selected DUT does. Relative cycle 0 is the start cycle.
    task automatic do_run(input bit sel, input int wl, input int abort_at, input bit extra,
                          output int vcyc, output int nvalid, output int en_first, output int en_last,
                          output int got_cnt, output bit got_sat, output bit busy_ab);
        logic en, v, b;
        vcyc = -1; nvalid = 0; en_first = -1; en_last = -1;
        got_cnt = -1; got_sat = 1'b0; busy_ab = 1'b1;
        @(negedge clk);
        for (int rel = 0; rel < wl + 40; rel++) begin
            if (rel > 0) begin
                @(negedge clk);
                en = sel ? ifb.ro_en : ifa.ro_en;
                v  = sel ? ifb.cnt_valid : ifa.cnt_valid;
                b  = sel ? ifb.busy : ifa.busy;
                if (en) begin
                    if (en_first < 0) en_first = rel;
                    en_last = rel;
                end
                if (v) begin
                    nvalid++;
                    if (vcyc < 0) begin
                        vcyc    = rel;
                        got_cnt = sel ? int'(ifb.cnt) : int'(ifa.cnt);
                        got_sat = sel ? ifb.cnt_sat : ifa.cnt_sat;
                    end
                end
                if (rel == abort_at + 1) busy_ab = b;
            end
            if (rel == 0) drive(1'b1, 1'b0, wl[15:0]);
            else drive(extra && (rel == 3 || rel == 20), rel == abort_at, 16'($urandom));
        end
        drive(1'b0, 1'b0, 16'd0);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        compared++;
        if ({ifa.ro_en, ifa.busy, ifa.cnt, ifa.cnt_valid, ifa.cnt_sat} !== 20'd0 ||
            {ifb.ro_en, ifb.busy, ifb.cnt, ifb.cnt_valid, ifb.cnt_sat} !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_values: a=%b b=%b want all zero",
                     {ifa.ro_en, ifa.busy, ifa.cnt, ifa.cnt_valid, ifa.cnt_sat},
                     {ifb.ro_en, ifb.busy, ifb.cnt, ifb.cnt_valid, ifb.cnt_sat});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_nominal;
        int vc, nv, ef, el, gc; bit gs, ba;
        exp_t e;
        sb.push_back('{73, 7, 9, 1'b0});
        do_run(1'b0, 64, -10, 1'b0, vc, nv, ef, el, gc, gs, ba);
        e = sb.pop_front();
        compared++;
        if (vc !== e.vcyc) begin mismatched++; $display("FAIL nominal_latency: got %0d want %0d", vc, e.vcyc); end
        compared++;
        if (gc < e.lo || gc > e.hi) begin mismatched++; $display("FAIL nominal_cnt: got %0d want %0d..%0d", gc, e.lo, e.hi); end
        compared++;
        if (gs !== e.sat || nv !== 1) begin mismatched++; $display("FAIL nominal_sat_pulse: sat %0d pulses %0d want 0/1", gs, nv); end
        compared++;
        if (ef !== 1 || el !== 72) begin mismatched++; $display("FAIL nominal_ro_en: window %0d..%0d want 1..72", ef, el); end
    endtask

    task automatic test_saturation;
        int vc, nv, ef, el, gc; bit gs, ba;
        exp_t e;
        sb.push_back('{109, 15, 15, 1'b1});
        do_run(1'b1, 100, -10, 1'b0, vc, nv, ef, el, gc, gs, ba);
        e = sb.pop_front();
        compared++;
        if (vc !== e.vcyc || gc !== e.lo || gs !== e.sat) begin
            mismatched++;
            $display("FAIL sat_run: cyc %0d cnt %0d sat %0d want %0d/%0d/%0d", vc, gc, gs, e.vcyc, e.lo, e.sat);
        end
        sb.push_back('{17, 2, 2, 1'b0});
        do_run(1'b1, 8, -10, 1'b0, vc, nv, ef, el, gc, gs, ba);
        e = sb.pop_front();
        compared++;
        if (vc !== e.vcyc || gc !== e.lo || gs !== e.sat) begin
            mismatched++;
            $display("FAIL sat_clear: cyc %0d cnt %0d sat %0d want %0d/%0d/%0d", vc, gc, gs, e.vcyc, e.lo, e.sat);
        end
    endtask

    task automatic test_abort;
        int vc, nv, ef, el, gc; bit gs, ba;
        exp_t e;
        sb.push_back('{25, 2, 2, 1'b0});
        do_run(1'b0, 16, -10, 1'b0, vc, nv, ef, el, gc, gs, ba);
        e = sb.pop_front();
        compared++;
        if (vc !== e.vcyc || gc !== e.lo) begin
            mismatched++;
            $display("FAIL abort_prerun: cyc %0d cnt %0d want %0d/%0d", vc, gc, e.vcyc, e.lo);
        end
        do_run(1'b0, 64, 20, 1'b0, vc, nv, ef, el, gc, gs, ba);
        compared++;
        if (nv !== 0) begin mismatched++; $display("FAIL abort_no_valid: got %0d pulses want 0", nv); end
        compared++;
        if (el !== 20 || ba !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_stop: ro_en last %0d busy@21 %0d want 20/0", el, ba);
        end
        compared++;
        if (ifa.cnt !== 16'd2 || ifa.cnt_sat !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_hold: cnt %0d sat %0d want 2/0", ifa.cnt, ifa.cnt_sat);
        end
    endtask

    task automatic test_zero_window;
        int vc, nv, ef, el, gc; bit gs, ba;
        exp_t e;
        sb.push_back('{9, 0, 0, 1'b0});
        do_run(1'b0, 0, -10, 1'b0, vc, nv, ef, el, gc, gs, ba);
        e = sb.pop_front();
        compared++;
        if (vc !== e.vcyc || gc !== e.lo || gs !== e.sat || nv !== 1) begin
            mismatched++;
            $display("FAIL zero_win: cyc %0d cnt %0d sat %0d pulses %0d want %0d/%0d/%0d/1", vc, gc, gs, nv, e.vcyc, e.lo, e.sat);
        end
        compared++;
        if (ef !== 1 || el !== 8) begin mismatched++; $display("FAIL zero_win_ro_en: window %0d..%0d want 1..8", ef, el); end
    endtask

    task automatic test_back_to_back;
        int vc, nv, ef, el, gc; bit gs, ba;
        exp_t e;
        sb.push_back('{73, 7, 9, 1'b0});
        do_run(1'b0, 64, -10, 1'b1, vc, nv, ef, el, gc, gs, ba);
        e = sb.pop_front();
        compared++;
        if (nv !== 1 || vc !== e.vcyc) begin
            mismatched++;
            $display("FAIL busy_start: pulses %0d cyc %0d want 1/%0d", nv, vc, e.vcyc);
        end
        compared++;
        if (gc < e.lo || gc > e.hi || el !== 72) begin
            mismatched++;
            $display("FAIL busy_start_cnt: cnt %0d ro_en last %0d want %0d..%0d/72", gc, el, e.lo, e.hi);
        end
    endtask

    task automatic test_reset_mid;
        int vc, nv, ef, el, gc; bit gs, ba;
        exp_t e;
        @(negedge clk);
        drive(1'b1, 1'b0, 16'd64);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'd0);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({ifa.ro_en, ifa.busy, ifa.cnt, ifa.cnt_valid, ifa.cnt_sat} !== 20'd0) begin
            mismatched++;
            $display("FAIL reset_mid: outputs %b want all zero", {ifa.ro_en, ifa.busy, ifa.cnt, ifa.cnt_valid, ifa.cnt_sat});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (ifa.busy !== 1'b0 || ifa.ro_en !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle: busy %0d ro_en %0d want 0/0", ifa.busy, ifa.ro_en);
        end
        sb.push_back('{13, 0, 1, 1'b0});
        do_run(1'b0, 4, -10, 1'b0, vc, nv, ef, el, gc, gs, ba);
        e = sb.pop_front();
        compared++;
        if (vc !== e.vcyc || gc < e.lo || gc > e.hi || nv !== 1) begin
            mismatched++;
            $display("FAIL reset_rerun: cyc %0d cnt %0d pulses %0d want %0d/%0d..%0d/1", vc, gc, nv, e.vcyc, e.lo, e.hi);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 16'd0);
        test_reset();
        test_nominal();
        test_saturation();
        test_abort();
        test_zero_window();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
